// File: rtl/vedic_mac_accumulator.sv
// ============================================================================
// Module      : vedic_mac_accumulator
// Description : Streaming 4x4 Vedic multiply-accumulate with valid/ready I/O.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vedic_2_x_2 (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);
    logic w_cross0;
    logic w_cross1;
    logic w_carry;

    assign w_cross0 = a_i[1] & b_i[0];
    assign w_cross1 = a_i[0] & b_i[1];
    assign w_carry  = w_cross0 & w_cross1;
    assign p_o[0]   = a_i[0] & b_i[0];
    assign p_o[1]   = w_cross0 ^ w_cross1;
    assign p_o[2]   = (a_i[1] & b_i[1]) ^ w_carry;
    assign p_o[3]   = (a_i[1] & b_i[1]) & w_carry;
endmodule

module vedic_4_x_4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);
    logic [3:0] w_ll;
    logic [3:0] w_hl;
    logic [3:0] w_lh;
    logic [3:0] w_hh;

    vedic_2_x_2 u_ll (.a_i(a_i[1:0]), .b_i(b_i[1:0]), .p_o(w_ll));
    vedic_2_x_2 u_hl (.a_i(a_i[3:2]), .b_i(b_i[1:0]), .p_o(w_hl));
    vedic_2_x_2 u_lh (.a_i(a_i[1:0]), .b_i(b_i[3:2]), .p_o(w_lh));
    vedic_2_x_2 u_hh (.a_i(a_i[3:2]), .b_i(b_i[3:2]), .p_o(w_hh));

    // Vertically-and-crosswise partial products recombined at their weights.
    assign p_o = {4'b0000, w_ll} + {2'b00, w_hl, 2'b00}
               + {2'b00, w_lh, 2'b00} + {w_hh, 4'b0000};
endmodule

module vedic_mac_accumulator #(
    parameter int LEN   = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    localparam int             CW    = $clog2(LEN + 1);
    localparam logic [CW-1:0]  LEN_C = CW'(LEN);
    localparam logic [CW-1:0]  ONE_C = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    issue_q, issue_d;
    logic [CW-1:0]    acc_cnt_q, acc_cnt_d;
    logic [7:0]       prod_q, prod_d;
    logic             prod_vld_q, prod_vld_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       mult;
    logic [ACC_W:0]   sum;
    logic             accept;

    vedic_4_x_4 u_mult (.a_i(a), .b_i(b), .p_o(mult));

    assign sum = {1'b0, acc_q} + (ACC_W+1)'(prod_q);

    always_comb begin
        state_d    = state_q;
        issue_d    = issue_q;
        acc_cnt_d  = acc_cnt_q;
        prod_d     = prod_q;
        prod_vld_d = 1'b0;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d     = '0;
                    ovf_d     = 1'b0;
                    issue_d   = '0;
                    acc_cnt_d = '0;
                    state_d   = S_ACCUM;
                end
            end
            S_ACCUM: begin
                in_ready = (issue_q < LEN_C);
                accept   = in_valid && in_ready;
                if (accept) begin
                    prod_d     = mult;
                    prod_vld_d = 1'b1;
                    issue_d    = issue_q + ONE_C;
                end
                if (prod_vld_q) begin
                    acc_d     = sum[ACC_W-1:0];
                    ovf_d     = ovf_q | sum[ACC_W];
                    acc_cnt_d = acc_cnt_q + ONE_C;
                    if (acc_cnt_d == LEN_C) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            issue_q    <= '0;
            acc_cnt_q  <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            issue_q    <= issue_d;
            acc_cnt_q  <= acc_cnt_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
        end
    end

    assign acc_out  = acc_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != S_IDLE);
endmodule

`default_nettype wire
